// File: rtl/seq_tail_lights_ctrl.sv
// -----------------------------------------------------------------------------
// seq_tail_lights_ctrl
//
// Sequential tail-light controller with built-in step and flash timing.
// Drives N_LAMPS lamps per side. Turn requests light a growing bar from the
// innermost lamp outwards, then all-off, then repeat. Hazard flashes both sides
// together. Brake lights every side that is not currently sequencing.
//
// Parameters:
//   N_LAMPS     lamps per side (>=1); bit 0 innermost, bit N_LAMPS-1 outermost
//   STEP_CYCLES clk cycles per turn-sequence step (>=1)
//   HAZ_CYCLES  clk cycles per hazard ON or OFF half-period (>=1)
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-high reset
//   left     in   left turn request (level)
//   right    in   right turn request (level)
//   haz      in   hazard request (level)
//   brake    in   brake pedal (level)
//   lamps_l  out  left lamps, registered
//   lamps_r  out  right lamps, registered
//   mode     out  current mode: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZ; registered
// -----------------------------------------------------------------------------
module seq_tail_lights_ctrl #(
  parameter int N_LAMPS     = 3,
  parameter int STEP_CYCLES = 25_000_000,
  parameter int HAZ_CYCLES  = 25_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               left,
  input  logic               right,
  input  logic               haz,
  input  logic               brake,
  output logic [N_LAMPS-1:0] lamps_l,
  output logic [N_LAMPS-1:0] lamps_r,
  output logic [1:0]         mode
);

  localparam int MAX_CYCLES = (STEP_CYCLES > HAZ_CYCLES) ? STEP_CYCLES : HAZ_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int STEP_W     = $clog2(N_LAMPS + 1);

  // The counter holds "cycles left in this step minus one", so a step of
  // STEP_CYCLES cycles reloads with STEP_CYCLES-1 and advances when it hits 0.
  localparam logic [CNT_W-1:0]  STEP_RELOAD = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HAZ_RELOAD  = CNT_W'(HAZ_CYCLES - 1);
  localparam logic [STEP_W-1:0] TURN_LAST   = STEP_W'(N_LAMPS);
  // Hazard reuses the step index as its phase: 0 = ON, 1 = OFF.
  localparam logic [STEP_W-1:0] HAZ_LAST    = STEP_W'(1);

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_LEFT  = 2'd1,
    MODE_RIGHT = 2'd2,
    MODE_HAZ   = 2'd3
  } mode_t;

  mode_t               mode_q, mode_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_LAMPS-1:0]  lamps_l_d, lamps_r_d;
  logic [N_LAMPS-1:0]  turn_pat;
  logic [N_LAMPS-1:0]  brake_pat;
  logic [CNT_W-1:0]    reload;
  logic [STEP_W-1:0]   last_step;

  // ---------------------------------------------------------------------------
  // Next-state and next-output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    mode_d    = MODE_IDLE;
    step_d    = step_q;
    cnt_d     = cnt_q;
    lamps_l_d = '0;
    lamps_r_d = '0;
    turn_pat  = '0;

    // Request priority: hazard first, then an unambiguous turn.
    if (haz)                mode_d = MODE_HAZ;
    else if (left && !right) mode_d = MODE_LEFT;
    else if (right && !left) mode_d = MODE_RIGHT;
    else                     mode_d = MODE_IDLE;

    reload    = (mode_d == MODE_HAZ) ? HAZ_RELOAD : STEP_RELOAD;
    last_step = (mode_d == MODE_HAZ) ? HAZ_LAST : TURN_LAST;

    // A mode change restarts the sequence and overrides any step advance due
    // on the same edge; IDLE simply parks at step 0 with the counter loaded.
    if (mode_d != mode_q || mode_d == MODE_IDLE) begin
      step_d = '0;
      cnt_d  = reload;
    end else if (cnt_q == '0) begin
      cnt_d  = reload;
      step_d = (step_q == last_step) ? '0 : step_q + STEP_W'(1);
    end else begin
      cnt_d  = cnt_q - CNT_W'(1);
    end

    // Step k < N_LAMPS lights the innermost k+1 lamps; step N_LAMPS is dark.
    for (int i = 0; i < N_LAMPS; i++) begin
      turn_pat[i] = (step_d < TURN_LAST) && (int'(step_d) >= i);
    end

    brake_pat = brake ? '1 : '0;

    unique case (mode_d)
      MODE_LEFT: begin
        lamps_l_d = turn_pat;
        lamps_r_d = brake_pat;
      end
      MODE_RIGHT: begin
        lamps_l_d = brake_pat;
        lamps_r_d = turn_pat;
      end
      MODE_HAZ: begin
        lamps_l_d = (step_d == '0) ? '1 : '0;
        lamps_r_d = (step_d == '0) ? '1 : '0;
      end
      default: begin
        lamps_l_d = brake_pat;
        lamps_r_d = brake_pat;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      mode_q  <= MODE_IDLE;
      step_q  <= '0;
      cnt_q   <= STEP_RELOAD;
      lamps_l <= '0;
      lamps_r <= '0;
    end else begin
      mode_q  <= mode_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      lamps_l <= lamps_l_d;
      lamps_r <= lamps_r_d;
    end
  end

  assign mode = mode_q;

endmodule
